// File: rtl/spi_reg_bus_master.sv
// SPI mode-0 slave that turns host frames into register-bus writes and reads.
// Frame, MSB first: [write flag][address][data]; read data returns on MISO.
module spi_reg_bus_master #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  i_clk_10,
  input  logic                  i_rst_n,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_busy,
  output logic                  o_frame_err
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned LAT_W     = $clog2(RD_LATENCY + 2);
  localparam int unsigned RX_W      = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_RD_WAIT   = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic       r_sclk_d, r_cs_d;
  logic       w_sclk_rise, w_sclk_fall, w_cs_n, w_cs_fall, w_mosi;

  // cs_n synchroniser resets to "selected" so a frame already in flight at reset is skipped
  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_cs_sync   <= {r_cs_sync[0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      r_sclk_d    <= r_sclk_sync[1];
      r_cs_d      <= r_cs_sync[1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
  assign w_cs_n      = r_cs_sync[1];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
  assign w_mosi      = r_mosi_sync[1];

  logic [2:0]            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt, w_cnt_nxt;
  logic [LAT_W-1:0]      r_lat, w_lat_nxt;
  logic [RX_W-2:0]       r_rx, w_rx_nxt;
  logic [RX_W-1:0]       w_rx_shift;
  logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic r_wr, w_wr_nxt, r_miso, w_miso_nxt, r_busy, w_busy_nxt;
  logic r_err, w_err_nxt, r_is_wr, w_is_wr_nxt, r_ovr, w_ovr_nxt;

  assign w_rx_shift = {r_rx, w_mosi};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_lat_nxt   = r_lat;
    w_rx_nxt    = r_rx;
    w_tx_nxt    = r_tx;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wr_nxt    = 1'b0;
    w_miso_nxt  = r_miso;
    w_busy_nxt  = r_busy;
    w_err_nxt   = 1'b0;
    w_is_wr_nxt = r_is_wr;
    w_ovr_nxt   = r_ovr;

    if (w_cs_fall)
      w_cnt_nxt = '0;
    else if (w_sclk_rise && (r_bit_cnt != CNT_W'(FRAME_LEN)))
      w_cnt_nxt = r_bit_cnt + CNT_W'(1);
    if (w_sclk_rise)
      w_rx_nxt = w_rx_shift[RX_W-2:0];

    case (r_state)
      S_WAIT_IDLE: begin
        w_busy_nxt = 1'b0;
        w_miso_nxt = 1'b0;
        if (w_cs_n) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        w_miso_nxt = 1'b0;
        if (w_cs_fall) begin
          w_state_nxt = S_ADDR;
          w_busy_nxt  = 1'b1;
          w_ovr_nxt   = 1'b0;
        end
      end
      S_ADDR: begin
        if (w_cs_n) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise && (r_bit_cnt == CNT_W'(ADDR_WIDTH))) begin
          w_addr_nxt  = w_rx_shift[ADDR_WIDTH-1:0];
          w_is_wr_nxt = w_rx_shift[ADDR_WIDTH];
          w_lat_nxt   = '0;
          w_state_nxt = w_rx_shift[ADDR_WIDTH] ? S_DATA : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_cs_n) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_lat == LAT_W'(RD_LATENCY)) begin
          w_tx_nxt    = i_rd_data;
          w_state_nxt = S_DATA;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      S_DATA: begin
        // final bit wins over a cs_n release seen in the same clock
        if (w_sclk_rise && (r_bit_cnt == CNT_W'(FRAME_LEN - 1))) begin
          if (r_is_wr) begin
            w_data_nxt = w_rx_shift[DATA_WIDTH-1:0];
            w_wr_nxt   = 1'b1;
          end
          if (w_cs_n) begin
            w_busy_nxt  = 1'b0;
            w_miso_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (w_cs_n) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_miso_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_sclk_fall && !r_is_wr) begin
          w_miso_nxt = r_tx[DATA_WIDTH-1];
          w_tx_nxt   = {r_tx[DATA_WIDTH-2:0], 1'b0};
        end
      end
      S_DONE: begin
        if (w_cs_n) begin
          w_busy_nxt  = 1'b0;
          w_miso_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise && !r_ovr) begin
          w_err_nxt = 1'b1;
          w_ovr_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_miso_nxt  = 1'b0;
        w_state_nxt = S_WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_WAIT_IDLE;
      r_bit_cnt <= '0;
      r_lat     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wr      <= 1'b0;
      r_miso    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_is_wr   <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_lat     <= w_lat_nxt;
      r_rx      <= w_rx_nxt;
      r_tx      <= w_tx_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_wr      <= w_wr_nxt;
      r_miso    <= w_miso_nxt;
      r_busy    <= w_busy_nxt;
      r_err     <= w_err_nxt;
      r_is_wr   <= w_is_wr_nxt;
      r_ovr     <= w_ovr_nxt;
    end
  end

  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_wr        = r_wr;
  assign o_miso      = r_miso;
  assign o_busy      = r_busy;
  assign o_frame_err = r_err;

endmodule

// File: tb/tb_spi_reg_bus_master.sv
// Directed bench for spi_reg_bus_master: host drives 1 MHz mode-0 frames,
// a small register-file model answers reads one clock after the address.
`timescale 1ns/1ps
module tb_spi_reg_bus_master;

  localparam int HALF = 500;
  localparam int GAP  = 2000;

  logic       clk, rst_n, sclk, cs_n, mosi, miso, wr, busy, ferr;
  logic [6:0] addr;
  logic [7:0] data, rd_data;
  logic [7:0] mem [0:127];

  int n_cmp, n_mis;
  int wr_cnt, err_cnt;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  spi_reg_bus_master dut (
    .i_clk_10(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n),
    .i_mosi(mosi), .o_miso(miso), .o_addr(addr), .o_data(data),
    .o_wr(wr), .i_rd_data(rd_data), .o_busy(busy), .o_frame_err(ferr)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) rd_data <= mem[addr];

  // pulse bookkeeping sampled on the falling edge
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = addr;
      wr_data = data;
    end
    if (ferr === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #(HALF);
    sclk = 1'b1;
    m = miso;
    #(HALF);
    sclk = 1'b0;
  endtask

  // bits beyond the 16-bit word are sent as 1s
  task automatic spi_frame(input logic [15:0] word, input int nbits, input bit raise_cs,
                           output logic [17:0] rx);
    logic m;
    logic b;
    rx = '0;
    cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? word[15-i] : 1'b1;
      spi_bit(b, m);
      rx = {rx[16:0], m};
    end
    mosi = 1'b0;
    #(HALF);
    if (raise_cs) begin
      cs_n = 1'b1;
      #(GAP);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #300;
    n_cmp++; if ({addr, data, wr, miso, busy, ferr} !== 19'd0) begin
      n_mis++; $display("FAIL reset_outputs: got addr=%h data=%h wr=%b miso=%b busy=%b err=%b want all 0",
                        addr, data, wr, miso, busy, ferr);
    end
    rst_n = 1'b1;
    #500;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [17:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h8155, 16, 1'b1, rx);
    n_cmp++; if (wr_cnt !== w0 + 1) begin n_mis++; $display("FAIL write_pulses: got %0d want %0d", wr_cnt - w0, 1); end
    n_cmp++; if (wr_addr !== 7'h01) begin n_mis++; $display("FAIL write_addr: got %h want 01", wr_addr); end
    n_cmp++; if (wr_data !== 8'h55) begin n_mis++; $display("FAIL write_data: got %h want 55", wr_data); end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL write_err: got %0d want 0", err_cnt - e0); end
    n_cmp++; if (rx[15:0] !== 16'h0000) begin n_mis++; $display("FAIL write_miso: got %h want 0000", rx[15:0]); end
  endtask

  task automatic test_read();
    logic [17:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h0200, 16, 1'b0, rx);
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL read_busy_in_frame: got %b want 1", busy); end
    n_cmp++; if (rx[7:0] !== 8'hA5) begin n_mis++; $display("FAIL read_miso: got %h want a5", rx[7:0]); end
    n_cmp++; if (addr !== 7'h02) begin n_mis++; $display("FAIL read_addr: got %h want 02", addr); end
    cs_n = 1'b1;
    #(GAP);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL read_busy_after: got %b want 0", busy); end
    n_cmp++; if (miso !== 1'b0) begin n_mis++; $display("FAIL read_miso_idle: got %b want 0", miso); end
    n_cmp++; if (wr_cnt !== w0) begin n_mis++; $display("FAIL read_no_wr: got %0d want 0", wr_cnt - w0); end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL read_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_abort();
    logic [17:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h8633, 10, 1'b1, rx);
    n_cmp++; if (wr_cnt !== w0) begin n_mis++; $display("FAIL abort_no_wr: got %0d want 0", wr_cnt - w0); end
    n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL abort_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (data !== 8'h55) begin n_mis++; $display("FAIL abort_data_kept: got %h want 55", data); end
    spi_frame(16'h870A, 16, 1'b1, rx);
    n_cmp++; if (wr_cnt !== w0 + 1) begin n_mis++; $display("FAIL abort_next_wr: got %0d want 1", wr_cnt - w0); end
    n_cmp++; if ({wr_addr, wr_data} !== {7'h07, 8'h0A}) begin
      n_mis++; $display("FAIL abort_next_addr_data: got %h/%h want 07/0a", wr_addr, wr_data);
    end
    n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL abort_next_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_overlength();
    logic [17:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h83FF, 18, 1'b1, rx);
    n_cmp++; if (wr_cnt !== w0 + 1) begin n_mis++; $display("FAIL over_wr: got %0d want 1", wr_cnt - w0); end
    n_cmp++; if ({wr_addr, wr_data} !== {7'h03, 8'hFF}) begin
      n_mis++; $display("FAIL over_addr_data: got %h/%h want 03/ff", wr_addr, wr_data);
    end
    n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL over_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] rx;
    logic m;
    logic [15:0] w;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    w = 16'h8C3C;
    cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < 5; i++) spi_bit(w[15-i], m);
    mosi = w[10];
    #200;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({addr, data, busy, wr, miso, ferr} !== 19'd0) begin
      n_mis++; $display("FAIL midrst_async: got addr=%h data=%h busy=%b wr=%b miso=%b err=%b want all 0",
                        addr, data, busy, wr, miso, ferr);
    end
    #199;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) spi_bit(1'b1, m);
    #(HALF);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL midrst_busy: got %b want 0", busy); end
    cs_n = 1'b1;
    #(GAP);
    n_cmp++; if (wr_cnt !== w0) begin n_mis++; $display("FAIL midrst_no_wr: got %0d want 0", wr_cnt - w0); end
    spi_frame(16'h8801, 16, 1'b1, rx);
    n_cmp++; if (wr_cnt !== w0 + 1) begin n_mis++; $display("FAIL midrst_next_wr: got %0d want 1", wr_cnt - w0); end
    n_cmp++; if ({addr, data} !== {7'h08, 8'h01}) begin
      n_mis++; $display("FAIL midrst_next_addr_data: got %h/%h want 08/01", addr, data);
    end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL midrst_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h8511, 16, 1'b1, rx);
    n_cmp++; if ({wr_addr, wr_data} !== {7'h05, 8'h11}) begin
      n_mis++; $display("FAIL b2b_first: got %h/%h want 05/11", wr_addr, wr_data);
    end
    spi_frame(16'h86E2, 16, 1'b1, rx);
    n_cmp++; if ({wr_addr, wr_data} !== {7'h06, 8'hE2}) begin
      n_mis++; $display("FAIL b2b_second: got %h/%h want 06/e2", wr_addr, wr_data);
    end
    n_cmp++; if (wr_cnt !== w0 + 2) begin n_mis++; $display("FAIL b2b_pulses: got %0d want 2", wr_cnt - w0); end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; wr_cnt = 0; err_cnt = 0;
    wr_addr = '0; wr_data = '0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[2] = 8'hA5;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overlength();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
